// File: rtl/lz77_decoder.sv
// LZ77 token decoder: expands (offset, match_len, char_nxt) tokens into a
// registered character stream using a 9-entry history shift register.
module lz77_decoder #(
    parameter logic [7:0] END_CHAR = 8'h24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] offset,
    input  logic [2:0] match_len,
    input  logic [7:0] char_nxt,
    output logic       out_valid,
    output logic [7:0] out_char,
    output logic       finish
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_LIT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [71:0] hist_r;      // hist[i] lives in bits [8*i +: 8]
    logic [3:0]  off_r;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_nxt_s;
    logic [7:0]  char_r;
    logic        out_valid_r;
    logic [7:0]  out_char_r;
    logic        finish_r;
    logic        accept_s;
    logic        emit_s;
    logic        fin_s;
    logic [7:0]  emit_char_s;

    function automatic logic [7:0] hist_at(input logic [71:0] h, input logic [3:0] idx);
        case (idx)
            4'd0:    return h[7:0];
            4'd1:    return h[15:8];
            4'd2:    return h[23:16];
            4'd3:    return h[31:24];
            4'd4:    return h[39:32];
            4'd5:    return h[47:40];
            4'd6:    return h[55:48];
            4'd7:    return h[63:56];
            default: return h[71:64];
        endcase
    endfunction

    function automatic logic [3:0] clamp_offset(input logic [3:0] o);
        if (o > 4'd8) begin
            return 4'd8;
        end else begin
            return o;
        end
    endfunction

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_char  = out_char_r;
    assign finish    = finish_r;

    // Next-state and per-cycle emit decisions
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        emit_s      = 1'b0;
        fin_s       = 1'b0;
        emit_char_s = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s  = 1'b1;
                    cnt_nxt_s = match_len;
                    if (match_len != 3'd0) begin
                        state_nxt_s = ST_COPY;
                    end else begin
                        state_nxt_s = ST_LIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COPY: begin
                // Reading the live history each cycle makes overlapping copies work
                emit_s      = 1'b1;
                emit_char_s = hist_at(hist_r, off_r);
                cnt_nxt_s   = cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                    state_nxt_s = ST_LIT;
                end else begin
                    state_nxt_s = ST_COPY;
                end
            end
            ST_LIT: begin
                if (char_r != END_CHAR) begin
                    emit_s      = 1'b1;
                    emit_char_s = char_r;
                    state_nxt_s = ST_IDLE;
                end else begin
                    fin_s       = 1'b1;
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, token latch, history and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            hist_r      <= 72'h0;
            off_r       <= 4'd0;
            cnt_r       <= 3'd0;
            char_r      <= 8'h00;
            out_valid_r <= 1'b0;
            out_char_r  <= 8'h00;
            finish_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= emit_s;
            finish_r    <= finish_r | fin_s;
            if (accept_s) begin
                off_r  <= clamp_offset(offset);
                char_r <= char_nxt;
            end
            if (emit_s) begin
                hist_r     <= {hist_r[63:0], emit_char_s};
                out_char_r <= emit_char_s;
            end
        end
    end

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed bench for lz77_decoder: literal, copy, overlap, clamp, terminator,
// reset-abort and a self-encoded 2049-char end-to-end stream.
module tb_lz77_decoder;

    localparam int N = 2049;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] offset;
    logic [2:0] match_len;
    logic [7:0] char_nxt;
    logic       out_valid;
    logic [7:0] out_char;
    logic       finish;

    int         checks = 0;
    int         errors = 0;
    logic       cap_en = 1'b0;
    logic [7:0] cap_q[$];
    logic [7:0] src[N];

    lz77_decoder #(.END_CHAR(8'h24)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .offset(offset), .match_len(match_len), .char_nxt(char_nxt),
        .out_valid(out_valid), .out_char(out_char), .finish(finish)
    );

    always #5 clk = ~clk;

    // Collects every emitted char for the end-to-end comparison
    always @(negedge clk) begin
        if (cap_en && out_valid) cap_q.push_back(out_char);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic token(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
        int w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        offset    = o;
        match_len = l;
        char_nxt  = c;
        tick();
        in_valid = 1'b0;
        chk("busy_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic check_out(input logic [7:0] e, input string tag);
        tick();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, {24'd0, out_char}, {24'd0, e});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int p, best_len, best_off, len, w;
        reset = 1'b0; in_valid = 1'b0; offset = 4'd0; match_len = 3'd0; char_nxt = 8'h00;

        // Reset state
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_char", {24'd0, out_char}, 32'd0);
        chk("rst_finish", {31'd0, finish}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Two literals, one busy cycle each, out_char held between
        token(4'd0, 3'd0, 8'h61);
        check_out(8'h61, "lit_a");
        chk("lit_a_ready", {31'd0, in_ready}, 32'd1);
        token(4'd0, 3'd0, 8'h62);
        chk("hold_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_char", {24'd0, out_char}, 32'h61);
        check_out(8'h62, "lit_b");
        chk("lit_b_ready", {31'd0, in_ready}, 32'd1);

        // History "abc" then (2,3,'d') -> a,b,c,d
        token(4'd0, 3'd0, 8'h61); check_out(8'h61, "abc_a");
        token(4'd0, 3'd0, 8'h62); check_out(8'h62, "abc_b");
        token(4'd0, 3'd0, 8'h63); check_out(8'h63, "abc_c");
        token(4'd2, 3'd3, 8'h64);
        check_out(8'h61, "copy_a");
        check_out(8'h62, "copy_b");
        check_out(8'h63, "copy_c");
        check_out(8'h64, "copy_d");
        chk("copy_ready", {31'd0, in_ready}, 32'd1);

        // Overlap: 'x' then (0,7,'y')
        token(4'd0, 3'd0, 8'h78); check_out(8'h78, "ovl_lit");
        token(4'd0, 3'd7, 8'h79);
        for (int i = 0; i < 7; i++) check_out(8'h78, "ovl_x");
        check_out(8'h79, "ovl_y");

        // Offset 12 clamps to 8: hist[8] is '0' after literals '0'..'8'
        for (int i = 0; i < 9; i++) begin
            token(4'd0, 3'd0, 8'h30 + 8'(i));
            check_out(8'h30 + 8'(i), "clamp_fill");
        end
        token(4'd12, 3'd1, 8'h21);
        check_out(8'h30, "clamp_copy");
        check_out(8'h21, "clamp_lit");

        // Terminator after "pq"
        token(4'd0, 3'd0, 8'h70); check_out(8'h70, "term_p0");
        token(4'd0, 3'd0, 8'h71); check_out(8'h71, "term_q0");
        token(4'd1, 3'd2, 8'h24);
        check_out(8'h70, "term_p");
        check_out(8'h71, "term_q");
        tick();
        chk("term_no_valid", {31'd0, out_valid}, 32'd0);
        chk("term_finish", {31'd0, finish}, 32'd1);
        chk("term_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; offset = 4'd0; match_len = 3'd0; char_nxt = 8'h72;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_ready", {31'd0, in_ready}, 32'd0);
            chk("done_valid", {31'd0, out_valid}, 32'd0);
            chk("done_finish", {31'd0, finish}, 32'd1);
        end
        in_valid = 1'b0;

        // Reset in the second COPY cycle of a len-5 token
        do_reset();
        chk("done_rst_finish", {31'd0, finish}, 32'd0);
        token(4'd0, 3'd0, 8'h6d); check_out(8'h6d, "abort_m");
        token(4'd0, 3'd5, 8'h7a);
        check_out(8'h6d, "abort_copy1");
        reset = 1'b1; in_valid = 1'b1; offset = 4'd0; match_len = 3'd0; char_nxt = 8'h77;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_finish", {31'd0, finish}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_quiet", {31'd0, out_valid}, 32'd0);
        end
        token(4'd0, 3'd2, 8'h6b);
        check_out(8'h00, "cleared0");
        check_out(8'h00, "cleared1");
        check_out(8'h6b, "cleared_k");

        // Reset wins over a same-cycle token
        tick();
        reset = 1'b1; in_valid = 1'b1; offset = 4'd0; match_len = 3'd0; char_nxt = 8'h77;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("prio_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("prio_quiet", {31'd0, out_valid}, 32'd0);
        end

        // End-to-end: greedy-encode a 2049-char source and decode it
        for (int i = 0; i < N; i++) begin
            if (i > 0 && (i % 64) < 9) src[i] = src[i-1];
            else src[i] = 8'h61 + 8'($urandom_range(0, 3));
        end
        do_reset();
        cap_q.delete();
        cap_en = 1'b1;
        p = 0;
        while (p < N) begin
            best_len = 0;
            best_off = 0;
            for (int o = 0; o < 9; o++) begin
                if (o < p) begin
                    len = 0;
                    while (len < 7 && p + len < N - 1 && src[p+len] == src[p+len-o-1]) len++;
                    if (len > best_len) begin
                        best_len = len;
                        best_off = o;
                    end
                end
            end
            token(4'(best_off), 3'(best_len), src[p+best_len]);
            p += best_len + 1;
        end
        token(4'd0, 3'd0, 8'h24);
        w = 0;
        while (finish !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("e2e_finish", {31'd0, finish}, 32'd1);
        chk("e2e_count", cap_q.size(), N);
        chk("e2e_final_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < N && i < cap_q.size(); i++) begin
            chk("e2e_char", {24'd0, cap_q[i]}, {24'd0, src[i]});
        end
        cap_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lz77_decoder.md
LZ77_DECODER -- requirements
Module: lz77_decoder

Interface
REQ-001 The block SHALL have one clock, `clk`, and a synchronous, active-high reset, `reset`.
REQ-002 Port list SHALL be (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, token present.
- in_ready, out, 1, decoder can accept a token this cycle.
- offset, in, 4, match distance back from the most recent decoded char (0 = most recent).
- match_len, in, 3, number of chars to copy (0..7).
- char_nxt, in, 8, literal following the copy.
- out_valid, out, 1, out_char valid this cycle.
- out_char, out, 8, decoded character.
- finish, out, 1, end-of-stream reached.
REQ-003 Parameter SHALL be (name, default, meaning): END_CHAR, 8'h24, stream terminator literal.

Function
REQ-004 History SHALL be a 9-entry shift register hist[0..8] of 8 bits, where hist[0] is the most recently decoded char.
REQ-005 Each char emitted on out_char SHALL be shifted into hist[0] in the same cycle, with hist[i] moving to hist[i+1] and hist[8] discarded.
REQ-006 The state machine SHALL have the states IDLE, COPY, LIT and DONE; only IDLE SHALL assert in_ready.
REQ-007 A token SHALL be accepted on a cycle where in_valid=1 and in_ready=1; offset, match_len and char_nxt SHALL be latched that cycle.
REQ-008 After acceptance, the next state SHALL be COPY if match_len>0, otherwise LIT.
REQ-009 In COPY, each cycle SHALL register out_valid=1 and out_char=hist[off_latched] and shift that char into history.
REQ-010 In COPY, a 3-bit remaining counter SHALL start at match_len and decrement each cycle; COPY SHALL go to LIT in the cycle the counter reaches 0.
REQ-011 Reading hist[off] on every copy cycle SHALL correctly reproduce overlapping matches (match_len > offset+1).
REQ-012 In LIT with char != END_CHAR, the block SHALL register out_valid=1 and out_char=char, shift char into history, and go to IDLE.
REQ-013 In LIT with char == END_CHAR, the block SHALL register out_valid=0 and finish=1 and go to DONE; the terminator SHALL NOT be emitted or shifted into history.
REQ-014 DONE SHALL be absorbing: in_ready=0, out_valid=0, finish held at 1 until reset.
REQ-015 Latency SHALL be one cycle: the first output char of a token appears registered in the cycle after acceptance.
REQ-016 A token SHALL occupy match_len+2 cycles (accept + match_len copies + literal), and in_ready SHALL reassert in the cycle after the LIT output.
REQ-017 offset values 9..15 SHALL be clamped to 8 on latch.
REQ-018 in_valid while in_ready=0 SHALL be ignored, with no state change; upstream SHALL hold the token until accepted.
REQ-019 out_valid SHALL be asserted for exactly one cycle per emitted char; out_char SHALL hold its last value when out_valid=0.
REQ-020 There SHALL be no output backpressure; the consumer SHALL accept every out_valid char.

Reset
REQ-021 On reset=1 at a rising edge, the block SHALL set state=IDLE, hist[0..8]=8'h00, counter=0, out_valid=0, out_char=8'h00 and finish=0.
REQ-022 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-023 Reset asserted mid-COPY, mid-LIT or in DONE SHALL abort the token and produce no further out_valid, regardless of in_valid.
REQ-024 Reset SHALL take priority over token acceptance in the same cycle.

Verification
REQ-025 The bench SHALL drive literal tokens (0,0,'a'), (0,0,'b') -> out_char 'a' then 'b', each one cycle after acceptance, with in_ready low for exactly one cycle per token.
REQ-026 The bench SHALL drive the history "abc" followed by token (2,3,'d') -> out_char sequence a,b,c,d in 4 consecutive cycles.
REQ-027 The bench SHALL drive the overlap case: after 'x', token (0,7,'y') -> seven 'x' followed by 'y'.
REQ-028 The bench SHALL drive the terminator case: token (1,2,8'h24) after "pq" -> p,q emitted, then finish=1 with no out_valid; the following in_valid SHALL be ignored and in_ready SHALL stay 0.
REQ-029 The bench SHALL assert reset in the second COPY cycle of a len-5 token -> no further out_valid, finish=0, hist cleared, and in_ready=1 in the cycle after reset deasserts.
REQ-030 The bench SHALL run the end-to-end case: feed the encoder's token stream for a 2049-char image -> the decoded stream matches the source exactly, and finish rises after the last char.
